// File: rtl/half_adder_pkg.sv
// -----------------------------------------------------------------------------
// half_adder_pkg
//   Shared types and limits for the lane-parallel half adder.
//   HA_MAX_LATENCY : deepest pipeline the half_adder top will build.
//   ha_res_t       : one lane's result; carry sits in the MSB, so the struct
//                    read as a 2-bit value equals a + b for that lane.
// -----------------------------------------------------------------------------
package half_adder_pkg;

  localparam int HA_MAX_LATENCY = 4;

  typedef struct packed {
    logic carry;
    logic sum;
  } ha_res_t;

endpackage : half_adder_pkg

// File: rtl/half_adder_cell.sv
// -----------------------------------------------------------------------------
// half_adder_cell
//   One combinational half-adder lane.
//   Ports:
//     a, b : input bits of this lane
//     res  : {carry, sum} = a + b
//   Plain gates are used, so an X on a or b shows up only in this lane.
// -----------------------------------------------------------------------------
module half_adder_cell
  import half_adder_pkg::*;
(
  input  logic    a,
  input  logic    b,
  output ha_res_t res
);

  assign res.sum   = a ^ b;
  assign res.carry = a & b;

endmodule : half_adder_cell

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//   Registered, lane-parallel half adder. Each of WIDTH independent lanes
//   produces sum = a ^ b and carry = a & b. There is no carry between lanes.
//   The result passes through LATENCY register stages. A valid flag travels
//   alongside the data.
//   Parameters:
//     WIDTH   : number of lanes (>= 1)
//     LATENCY : register stages, 0..HA_MAX_LATENCY (0 = purely combinational)
//   Ports:
//     clk       : rising-edge clock (unused when LATENCY = 0)
//     rst       : asynchronous active-high reset that clears every stage
//                 (unused when LATENCY = 0)
//     in_valid  : qualifies a/b in this cycle
//     a, b      : addends, lane i = a[i], b[i]
//     sum       : per-lane sum
//     carry     : per-lane carry
//     out_valid : sum/carry hold a valid result
// -----------------------------------------------------------------------------
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             out_valid
);

  // Refuse to build with parameters outside the supported range.
  if (WIDTH < 1 || LATENCY < 0 || LATENCY > HA_MAX_LATENCY) begin : g_param_check
    $error("half_adder: WIDTH must be >= 1 and LATENCY must be 0..%0d", HA_MAX_LATENCY);
  end

  ha_res_t [WIDTH-1:0] cell_res;
  ha_res_t [WIDTH-1:0] out_res;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    half_adder_cell u_cell (
      .a   (a[gi]),
      .b   (b[gi]),
      .res (cell_res[gi])
    );
  end

  // Each stage owns its registers. Stage gi reads stage gi-1, and stage 1
  // reads the cells. The data registers load every cycle with no enable,
  // because out_valid alone qualifies the data downstream.
  for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_stage
    ha_res_t [WIDTH-1:0] res_reg;
    logic                valid_reg;
    ha_res_t [WIDTH-1:0] res_d;
    logic                valid_d;

    if (gi == 1) begin : g_first
      assign res_d   = cell_res;
      assign valid_d = in_valid;
    end else begin : g_next
      assign res_d   = g_stage[gi-1].res_reg;
      assign valid_d = g_stage[gi-1].valid_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_reg   <= '0;
        valid_reg <= 1'b0;
      end else begin
        res_reg   <= res_d;
        valid_reg <= valid_d;
      end
    end
  end

  if (LATENCY == 0) begin : g_comb_out
    // clk and rst have no function in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_res        = cell_res;
    assign out_valid      = in_valid;
  end else begin : g_reg_out
    assign out_res   = g_stage[LATENCY].res_reg;
    assign out_valid = g_stage[LATENCY].valid_reg;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_unpack
    assign sum[gi]   = out_res[gi].sum;
    assign carry[gi] = out_res[gi].carry;
  end

endmodule : half_adder

// File: tb/tb_half_adder.sv
// -----------------------------------------------------------------------------
// tb_half_adder
//   Drives several half_adder builds from one stimulus stream:
//   W1/L1, W4/L0, W4/L1, W4/L3 and W4/L4. The reference keeps a short history
//   of the inputs sampled at each rising edge. Reset wipes that history to
//   zeros. The expected output of an N-stage build is then the per-lane sum
//   a+b of the entry sampled N edges back.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_half_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] a, b;

  logic [0:0] sum_w1, carry_w1;
  logic       valid_w1;
  logic [3:0] sum_l0, carry_l0, sum_l1, carry_l1, sum_l3, carry_l3, sum_l4, carry_l4;
  logic       valid_l0, valid_l1, valid_l3, valid_l4;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  half_adder #(.WIDTH(1), .LATENCY(1)) u_w1_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
    .sum(sum_w1), .carry(carry_w1), .out_valid(valid_w1));
  half_adder #(.WIDTH(4), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .sum(sum_l0), .carry(carry_l0), .out_valid(valid_l0));
  half_adder #(.WIDTH(4), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .sum(sum_l1), .carry(carry_l1), .out_valid(valid_l1));
  half_adder #(.WIDTH(4), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .sum(sum_l3), .carry(carry_l3), .out_valid(valid_l3));
  half_adder #(.WIDTH(4), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .sum(sum_l4), .carry(carry_l4), .out_valid(valid_l4));

  // Input history: index 0 holds the values sampled at the most recent edge.
  logic       h_v [0:4];
  logic [3:0] h_a [0:4];
  logic [3:0] h_b [0:4];

  task automatic clear_hist();
    for (int i = 0; i < 5; i++) begin
      h_v[i] = 1'b0; h_a[i] = 4'd0; h_b[i] = 4'd0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_hist();
    end else begin
      for (int i = 4; i > 0; i--) begin
        h_v[i] = h_v[i-1]; h_a[i] = h_a[i-1]; h_b[i] = h_b[i-1];
      end
      h_v[0] = in_valid; h_a[0] = a; h_b[0] = b;
    end
  end

  // Reference result {valid, carry[3:0], sum[3:0]} from a lane-wise 2-bit add.
  function automatic logic [8:0] model(input logic v, input logic [3:0] aa, input logic [3:0] bb);
    logic [3:0] s, c;
    logic [1:0] t;
    for (int i = 0; i < 4; i++) begin
      t    = {1'b0, aa[i]} + {1'b0, bb[i]};
      s[i] = t[0];
      c[i] = t[1];
    end
    return {v, c, s};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_lat(input string tag);
    logic [8:0] e;
    e = model(h_v[0], h_a[0], h_b[0]);
    check({tag, "_l1"}, {valid_l1, carry_l1, sum_l1}, e);
    check({tag, "_w1"}, {valid_w1, carry_w1, sum_w1}, {e[8], e[4], e[0]});
    e = model(h_v[2], h_a[2], h_b[2]);
    check({tag, "_l3"}, {valid_l3, carry_l3, sum_l3}, e);
    e = model(h_v[3], h_a[3], h_b[3]);
    check({tag, "_l4"}, {valid_l4, carry_l4, sum_l4}, e);
  endtask

  // One transaction: drive on the falling edge, check the combinational build,
  // then check the registered builds just after the next rising edge.
  task automatic step(input logic v, input logic [3:0] aa, input logic [3:0] bb, input string tag);
    @(negedge clk);
    in_valid = v; a = aa; b = bb;
    #1;
    check({tag, "_l0"}, {valid_l0, carry_l0, sum_l0}, model(v, aa, bb));
    @(posedge clk);
    #1;
    check_lat(tag);
    $display("[TB] %s v=%0b a=%h b=%h -> l1 s=%h c=%h v=%0b", tag, v, aa, bb, sum_l1, carry_l1, valid_l1);
  endtask

  logic [3:0] vec_a [0:3];
  logic [3:0] vec_b [0:3];
  logic       gap_v [0:3];

  initial begin
    vec_a[0] = 4'd0; vec_b[0] = 4'd0; gap_v[0] = 1'b1;
    vec_a[1] = 4'd1; vec_b[1] = 4'd0; gap_v[1] = 1'b0;
    vec_a[2] = 4'd0; vec_b[2] = 4'd1; gap_v[2] = 1'b1;
    vec_a[3] = 4'd1; vec_b[3] = 4'd1; gap_v[3] = 1'b1;

    rst = 1'b1; in_valid = 1'b0; a = 4'd0; b = 4'd0;
    clear_hist();
    repeat (2) @(posedge clk);
    #1;
    check("reset_l1", {valid_l1, carry_l1, sum_l1}, 9'd0);
    check("reset_l4", {valid_l4, carry_l4, sum_l4}, 9'd0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: truth table, one cycle later on the W1/L1 build.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vec_a[i], vec_b[i], $sformatf("t1_v%0d", i));
      check($sformatf("t1_const%0d", i), {valid_w1, carry_w1, sum_w1},
            {1'b1, vec_a[i][0] & vec_b[i][0], vec_a[i][0] ^ vec_b[i][0]});
    end

    // Test 2: while rst is held, toggling inputs must not reach the outputs.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i % 2 == 0) ? 4'hF : 4'h0, (i % 2 == 0) ? 4'hF : 4'h0, "t2_hold");
      check("t2_zero_l1", {valid_l1, carry_l1, sum_l1}, 9'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 4'hF, 4'hF, "t2_rel");
    check("t2_first_valid", {valid_l1, carry_l1, sum_l1}, {1'b1, 4'hF, 4'h0});

    // Test 3: async reset between edges with results in flight.
    step(1'b1, 4'h3, 4'h5, "t3_a");
    step(1'b1, 4'hC, 4'hA, "t3_b");
    #2;
    rst = 1'b1;
    #1;
    check("t3_async_l3", {valid_l3, carry_l3, sum_l3}, 9'd0);
    check("t3_async_l4", {valid_l4, carry_l4, sum_l4}, 9'd0);
    check("t3_async_l1", {valid_l1, carry_l1, sum_l1}, 9'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 4'h0, 4'h0, "t3_drain");

    // Test 4: no carry between lanes.
    step(1'b1, 4'b1100, 4'b1010, "t4");
    check("t4_sum", {28'd0, sum_l1}, 32'b0110);
    check("t4_carry", {28'd0, carry_l1}, 32'b1000);

    // Test 5: same vectors with a valid gap pattern 1,0,1,1.
    for (int i = 0; i < 4; i++) step(gap_v[i], vec_a[i], vec_b[i], $sformatf("t5_v%0d", i));
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 4'h0, "t5_flush");

    // Test 6: randomized regression.
    for (int i = 0; i < 1000; i++)
      step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), "t6_rand");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_half_adder
